asrs_fu_scheduler: RTL and testbench

Scheduler that shares one add/sub functional unit among three add/sub reservation stations. It arbitrates their dispatch requests round-robin, latches the winner's operands, runs the operation for a fixed latency, and requests the common data bus (CDB). On CDB grant it broadcasts `{tag, result}` and pulses `confirma` back to the winning station so that station can free its entry. It sits between the add/sub reservation stations and the CDB arbiter.

---
 rtl/asrs_fu_scheduler.sv | 165 ++++++++++++++++
 tb/tb_asrs_fu_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/asrs_fu_scheduler.sv
// Shared add/sub functional unit for three reservation stations: round-robin
// dispatch, fixed-latency execute, CDB request/broadcast with completion pulse.
module asrs_fu_scheduler #(
    parameter int unsigned LAT = 2
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [2:0]  despacho,
    input  logic [47:0] Valor1,
    input  logic [47:0] Valor2,
    input  logic [8:0]  OP,
    input  logic [8:0]  ID_in,
    input  logic        cdb_grant,
    output logic [2:0]  confirma,
    output logic        fu_busy,
    output logic        cdb_req,
    output logic [18:0] CDB
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        WAIT_CDB = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  sel;
    logic [1:0]  last;
    logic [2:0]  tag;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] res;
    logic [2:0]  cnt;

    // Per-station slices; entry 3 is a dead slot so a 2-bit index never leaves the array.
    logic [15:0] v1_s [4];
    logic [15:0] v2_s [4];
    logic [2:0]  op_s [4];
    logic [2:0]  id_s [4];
    logic [3:0]  elig;

    assign v1_s[0] = Valor1[15:0];
    assign v1_s[1] = Valor1[31:16];
    assign v1_s[2] = Valor1[47:32];
    assign v1_s[3] = '0;
    assign v2_s[0] = Valor2[15:0];
    assign v2_s[1] = Valor2[31:16];
    assign v2_s[2] = Valor2[47:32];
    assign v2_s[3] = '0;
    assign op_s[0] = OP[2:0];
    assign op_s[1] = OP[5:3];
    assign op_s[2] = OP[8:6];
    assign op_s[3] = '0;
    assign id_s[0] = ID_in[2:0];
    assign id_s[1] = ID_in[5:3];
    assign id_s[2] = ID_in[8:6];
    assign id_s[3] = '0;

    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            elig[i] = despacho[i] && (id_s[i] != 3'b000);
        end
    end

    logic [1:0] p1;
    logic [1:0] p2;
    logic [1:0] win;
    logic       win_valid;

    // Priority rotates starting just after the last winner, wrapping mod 3.
    always_comb begin
        p1        = (last == 2'd2) ? 2'd0 : last + 2'd1;
        p2        = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
        win       = p1;
        win_valid = 1'b1;
        if (elig[p1]) begin
            win = p1;
        end else if (elig[p2]) begin
            win = p2;
        end else if (elig[last]) begin
            win = last;
        end else begin
            win_valid = 1'b0;
        end
    end

    logic [15:0] alu_res;

    always_comb begin
        alu_res = (op == 3'b001) ? (a - b) : (a + b);
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state    <= IDLE;
            sel      <= '0;
            last     <= 2'd2;
            tag      <= '0;
            a        <= '0;
            b        <= '0;
            op       <= '0;
            res      <= '0;
            cnt      <= '0;
            confirma <= '0;
            fu_busy  <= 1'b0;
            cdb_req  <= 1'b0;
            CDB      <= '0;
        end else begin
            confirma <= '0;
            CDB      <= '0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        sel     <= win;
                        last    <= win;
                        tag     <= id_s[win];
                        a       <= v1_s[win];
                        b       <= v2_s[win];
                        op      <= op_s[win];
                        cnt     <= 3'(LAT - 1);
                        state   <= EXEC;
                        fu_busy <= 1'b1;
                    end else begin
                        fu_busy <= 1'b0;
                    end
                    cdb_req <= 1'b0;
                end
                EXEC: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        res     <= alu_res;
                        state   <= WAIT_CDB;
                        cdb_req <= 1'b1;
                    end
                end
                WAIT_CDB: begin
                    if (cdb_grant) begin
                        state    <= DONE;
                        cdb_req  <= 1'b0;
                        CDB      <= {tag, res};
                        confirma <= 3'b001 << sel;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    fu_busy <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    fu_busy <= 1'b0;
                    cdb_req <= 1'b0;
                end
            endcase
        end
    end

    a_confirma_onehot: assert property (@(posedge CLK) disable iff (!CLR) $onehot0(confirma));
    a_cdb_only_with_confirma: assert property (@(posedge CLK) disable iff (!CLR)
        (CDB != '0) |-> (confirma != '0));

endmodule

// File: tb/tb_asrs_fu_scheduler.sv
// Directed bench for asrs_fu_scheduler: table of single operations plus
// reset, round-robin, tag-000 and CDB-stall sequences.
module tb_asrs_fu_scheduler;

    logic        CLK;
    logic        CLR;
    logic [2:0]  despacho;
    logic [47:0] Valor1;
    logic [47:0] Valor2;
    logic [8:0]  OP;
    logic [8:0]  ID_in;
    logic        cdb_grant;
    logic [2:0]  confirma;
    logic        fu_busy;
    logic        cdb_req;
    logic [18:0] CDB;

    int n_checks = 0;
    int n_fail   = 0;

    asrs_fu_scheduler #(.LAT(2)) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .despacho  (despacho),
        .Valor1    (Valor1),
        .Valor2    (Valor2),
        .OP        (OP),
        .ID_in     (ID_in),
        .cdb_grant (cdb_grant),
        .confirma  (confirma),
        .fu_busy   (fu_busy),
        .cdb_req   (cdb_req),
        .CDB       (CDB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int          st;
        logic [2:0]  tag;
        logic [15:0] v1;
        logic [15:0] v2;
        logic [2:0]  op;
        logic [18:0] exp_cdb;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_station(input int st, input logic [2:0] tag, input logic [15:0] v1,
                               input logic [15:0] v2, input logic [2:0] o);
        Valor1[st*16 +: 16] = v1;
        Valor2[st*16 +: 16] = v2;
        OP[st*3 +: 3]       = o;
        ID_in[st*3 +: 3]    = tag;
    endtask

    function automatic int dec(input logic [2:0] c);
        case (c)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 3;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[6];
        int n_seen;
        int c0;
        int c2;
        logic [2:0] exp_c;

        vecs[0] = '{1, 3'b010, 16'h0005, 16'h0003, 3'b000, 19'h20008};
        vecs[1] = '{0, 3'b001, 16'h0000, 16'h0001, 3'b001, 19'h1FFFF};
        vecs[2] = '{0, 3'b001, 16'hFFFF, 16'h0001, 3'b000, 19'h10000};
        vecs[3] = '{2, 3'b011, 16'h1234, 16'h1111, 3'b101, 19'h32345};
        vecs[4] = '{1, 3'b111, 16'h8000, 16'h0001, 3'b001, 19'h77FFF};
        vecs[5] = '{2, 3'b100, 16'hABCD, 16'h0033, 3'b011, 19'h4AC00};

        CLR = 1'b0; despacho = '0; Valor1 = '0; Valor2 = '0; OP = '0; ID_in = '0; cdb_grant = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_fu_busy", {31'd0, fu_busy}, 32'd0);
        check("reset_cdb_req", {31'd0, cdb_req}, 32'd0);
        check("reset_cdb", {13'd0, CDB}, 32'd0);
        check("reset_confirma", {29'd0, confirma}, 32'd0);
        CLR = 1'b1;
        @(negedge CLK);

        // Single operations: grant held high, winner drops despacho and inputs are scrambled.
        for (int i = 0; i < 6; i++) begin
            Valor1 = '0; Valor2 = '0; OP = '0; ID_in = '0;
            set_station(vecs[i].st, vecs[i].tag, vecs[i].v1, vecs[i].v2, vecs[i].op);
            despacho  = 3'b001 << vecs[i].st;
            cdb_grant = 1'b1;
            exp_c     = 3'b001 << vecs[i].st;
            @(negedge CLK);
            check("vec_busy", {31'd0, fu_busy}, 32'd1);
            check("vec_cdb_exec", {13'd0, CDB}, 32'd0);
            despacho = '0;
            Valor1 = {$urandom, $urandom};
            Valor2 = {$urandom, $urandom};
            OP     = 9'($urandom);
            @(negedge CLK);
            check("vec_confirma_exec", {29'd0, confirma}, 32'd0);
            @(negedge CLK);
            check("vec_cdb_req", {31'd0, cdb_req}, 32'd1);
            @(negedge CLK);
            check("vec_cdb_done", {13'd0, CDB}, {13'd0, vecs[i].exp_cdb});
            check("vec_confirma_done", {29'd0, confirma}, {29'd0, exp_c});
            check("vec_cdb_req_done", {31'd0, cdb_req}, 32'd0);
            @(negedge CLK);
            check("vec_cdb_after", {13'd0, CDB}, 32'd0);
            check("vec_confirma_after", {29'd0, confirma}, 32'd0);
            check("vec_busy_after", {31'd0, fu_busy}, 32'd0);
        end

        // Asynchronous reset in the middle of EXEC.
        Valor1 = '0; Valor2 = '0; OP = '0; ID_in = '0;
        set_station(0, 3'b001, 16'h0010, 16'h0020, 3'b000);
        despacho = 3'b001; cdb_grant = 1'b1;
        @(negedge CLK);
        check("rst_mid_busy_before", {31'd0, fu_busy}, 32'd1);
        #1 CLR = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, fu_busy}, 32'd0);
        check("rst_mid_cdb_req", {31'd0, cdb_req}, 32'd0);
        check("rst_mid_cdb", {13'd0, CDB}, 32'd0);
        check("rst_mid_confirma", {29'd0, confirma}, 32'd0);
        despacho = '0;
        @(negedge CLK);
        CLR = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("post_rst_idle_busy", {31'd0, fu_busy}, 32'd0);
            check("post_rst_idle_cdb", {13'd0, CDB}, 32'd0);
        end

        // Round robin: all three request, each drops on its confirma, then all re-request.
        set_station(0, 3'b001, 16'h0001, 16'h0001, 3'b000);
        set_station(1, 3'b010, 16'h0002, 16'h0002, 3'b000);
        set_station(2, 3'b011, 16'h0003, 16'h0003, 3'b000);
        despacho = 3'b111; cdb_grant = 1'b1;
        n_seen = 0;
        for (int cyc = 0; cyc < 80 && n_seen < 6; cyc++) begin
            @(negedge CLK);
            if (confirma != 3'b000) begin
                order[n_seen] = dec(confirma);
                n_seen++;
                despacho = despacho & ~confirma;
                if (n_seen == 3) despacho = 3'b111;
            end
        end
        despacho = '0;
        check("rr_count", n_seen, 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("rr_order", (i < n_seen) ? order[i] : -1, i % 3);
        end
        repeat (3) @(negedge CLK);

        // Tag 000 requester must never be granted while a valid requester is served.
        set_station(0, 3'b000, 16'h0101, 16'h0101, 3'b000);
        set_station(2, 3'b101, 16'h0202, 16'h0202, 3'b000);
        despacho = 3'b101; cdb_grant = 1'b1;
        c0 = 0; c2 = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge CLK);
            if (confirma[0]) c0++;
            if (confirma[2]) begin
                c2++;
                check("tag0_cdb", {13'd0, CDB}, {13'd0, 3'b101, 16'h0404});
                despacho[2] = 1'b0;
            end
        end
        check("tag0_never_granted", c0, 32'd0);
        check("tag0_valid_served", c2, 32'd1);
        check("tag0_idle_busy", {31'd0, fu_busy}, 32'd0);
        despacho = '0;
        @(negedge CLK);

        // CDB stall: grant pulse during EXEC is ignored, then ten cycles with grant low.
        set_station(1, 3'b110, 16'h1000, 16'h0234, 3'b000);
        despacho = 3'b010; cdb_grant = 1'b0;
        @(negedge CLK);
        check("stall_busy", {31'd0, fu_busy}, 32'd1);
        despacho = '0;
        cdb_grant = 1'b1;
        Valor1[31:16] = 16'h7777;
        @(negedge CLK);
        cdb_grant = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("stall_cdb_req", {31'd0, cdb_req}, 32'd1);
            check("stall_cdb", {13'd0, CDB}, 32'd0);
        end
        cdb_grant = 1'b1;
        @(negedge CLK);
        check("stall_cdb_done", {13'd0, CDB}, {13'd0, 19'h61234});
        check("stall_confirma_done", {29'd0, confirma}, 32'd2);
        cdb_grant = 1'b0;
        @(negedge CLK);
        check("stall_cdb_after", {13'd0, CDB}, 32'd0);
        check("stall_confirma_after", {29'd0, confirma}, 32'd0);
        check("stall_cdb_req_after", {31'd0, cdb_req}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
